// File: rtl/jtopl_wrqueue_if.sv
// Host-side register-write push port of the jtopl write queue.
// A push happens on any clk edge where wr_valid and wr_ready are both 1.
interface jtopl_wrqueue_if;
    logic [7:0] wr_reg;
    logic [7:0] wr_val;
    logic       wr_valid;
    logic       wr_ready;

    modport master (output wr_reg, output wr_val, output wr_valid, input wr_ready);
    modport slave  (input wr_reg, input wr_val, input wr_valid, output wr_ready);
endinterface

// File: rtl/jtopl_wrqueue.sv
// Write queue ahead of jtopl: buffers {reg,val} pushes and replays them as
// address-then-data bus cycles, enforcing the OPL post-write wait times.
module jtopl_wrqueue #(
    parameter int AW        = 4,
    parameter int ADDR_WAIT = 12,
    parameter int DATA_WAIT = 84
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cen,
    jtopl_wrqueue_if.slave      host,
    input  logic                clr_ovf,
    output logic                ovf,
    output logic [AW:0]         level,
    output logic                busy,
    output logic [7:0]          opl_din,
    output logic                opl_addr,
    output logic                opl_cs_n,
    output logic                opl_wr_n,
    output logic [2:0]          fsm_state
);

    localparam int          DEPTH     = 1 << AW;
    localparam logic [AW:0] FULL      = (AW + 1)'(DEPTH);
    localparam logic [7:0]  ADDR_LOAD = 8'(ADDR_WAIT - 1);
    localparam logic [7:0]  DATA_LOAD = 8'(DATA_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ASTB  = 3'd1,
        S_AWAIT = 3'd2,
        S_DSTB  = 3'd3,
        S_DWAIT = 3'd4
    } state_t;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [15:0]   head;
    logic          push;
    logic          pop;
    logic [AW:0]   level_next;

    state_t        state;
    state_t        state_next;
    logic [7:0]    cnt;
    logic [7:0]    cnt_next;
    logic [7:0]    val_hold;
    logic [7:0]    val_next;
    logic [7:0]    din_next;
    logic          addr_next;
    logic          strobe_n_next;

    assign push      = host.wr_valid & host.wr_ready;
    assign head      = mem[rd_ptr];
    assign fsm_state = state;

    always_comb begin
        level_next = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    // wr_ready is registered from the post-edge level, so a full queue refuses
    // a push even when a pop happens on that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            host.wr_ready <= 1'b0;
            ovf           <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level         <= level_next;
            host.wr_ready <= (level_next != FULL);
            if (clr_ovf)
                ovf <= 1'b0;
            else if (host.wr_valid && !host.wr_ready)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= {host.wr_reg, host.wr_val};
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        val_next      = val_hold;
        din_next      = opl_din;
        addr_next     = opl_addr;
        strobe_n_next = opl_cs_n;
        pop           = 1'b0;
        if (cen) begin
            case (state)
                S_IDLE: begin
                    if (level != '0) begin
                        pop           = 1'b1;
                        din_next      = head[15:8];
                        val_next      = head[7:0];
                        addr_next     = 1'b0;
                        strobe_n_next = 1'b0;
                        state_next    = S_ASTB;
                    end
                end
                S_ASTB: begin
                    strobe_n_next = 1'b1;
                    cnt_next      = ADDR_LOAD;
                    state_next    = S_AWAIT;
                end
                S_AWAIT: begin
                    if (cnt == 8'd0) begin
                        addr_next     = 1'b1;
                        din_next      = val_hold;
                        strobe_n_next = 1'b0;
                        state_next    = S_DSTB;
                    end else begin
                        cnt_next = cnt - 8'd1;
                    end
                end
                S_DSTB: begin
                    strobe_n_next = 1'b1;
                    cnt_next      = DATA_LOAD;
                    state_next    = S_DWAIT;
                end
                S_DWAIT: begin
                    if (cnt == 8'd0) begin
                        // Chain straight into the next address strobe when work is queued.
                        if (level != '0) begin
                            pop           = 1'b1;
                            din_next      = head[15:8];
                            val_next      = head[7:0];
                            addr_next     = 1'b0;
                            strobe_n_next = 1'b0;
                            state_next    = S_ASTB;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        cnt_next = cnt - 8'd1;
                    end
                end
                default: begin
                    strobe_n_next = 1'b1;
                    state_next    = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            val_hold <= 8'd0;
            opl_din  <= 8'd0;
            opl_addr <= 1'b0;
            opl_cs_n <= 1'b1;
            opl_wr_n <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            val_hold <= val_next;
            opl_din  <= din_next;
            opl_addr <= addr_next;
            opl_cs_n <= strobe_n_next;
            opl_wr_n <= strobe_n_next;
            busy     <= (level_next != '0) || (state_next != S_IDLE);
        end
    end

endmodule

// File: tb/tb_jtopl_wrqueue.sv
// Bench for jtopl_wrqueue: a cen-tick timeline model of the queue and bus,
// checked every cycle, plus directed timing and ordering scenarios.
module tb_jtopl_wrqueue;
  localparam int AW        = 4;
  localparam int ADDR_WAIT = 12;
  localparam int DATA_WAIT = 84;
  localparam int DEPTH     = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        clr_ovf;
  logic        ovf;
  logic        busy;
  logic [AW:0] level;
  logic [7:0]  opl_din;
  logic        opl_addr;
  logic        opl_cs_n;
  logic        opl_wr_n;
  logic [2:0]  fsm_state;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  jtopl_wrqueue_if host();

  jtopl_wrqueue #(.AW(AW), .ADDR_WAIT(ADDR_WAIT), .DATA_WAIT(DATA_WAIT)) dut (
    .clk(clk), .rst(rst), .cen(cen), .host(host), .clr_ovf(clr_ovf),
    .ovf(ovf), .level(level), .busy(busy), .opl_din(opl_din),
    .opl_addr(opl_addr), .opl_cs_n(opl_cs_n), .opl_wr_n(opl_wr_n),
    .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // reference model: queue contents plus a timeline of cen ticks per write
  logic [15:0] mq[$];
  int          tick;
  int          t0;
  bit          act;
  logic [15:0] cur;
  bit          m_ready;
  bit          m_ovf;
  bit          m_busy;
  logic        m_cs_n;
  logic        m_addr;
  logic [7:0]  m_din;

  initial begin : model
    int rel;
    int old_size;
    bit old_ready;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        act = 1'b0; tick = 0; t0 = 0;
        m_ready = 1'b0; m_ovf = 1'b0;
        m_cs_n = 1'b1; m_addr = 1'b0; m_din = 8'h00;
      end else begin
        old_ready = m_ready;
        old_size  = mq.size();
        if (clr_ovf) m_ovf = 1'b0;
        else if (host.wr_valid && !old_ready) m_ovf = 1'b1;
        if (cen) begin
          tick++;
          m_cs_n = 1'b1;
          if (act) begin
            rel = tick - t0;
            if (rel == 1 + ADDR_WAIT) begin
              m_cs_n = 1'b0; m_addr = 1'b1; m_din = cur[7:0];
            end
            if (rel == 2 + ADDR_WAIT + DATA_WAIT) act = 1'b0;
          end
          if (!act && old_size != 0) begin
            cur = mq.pop_front();
            act = 1'b1; t0 = tick;
            m_cs_n = 1'b0; m_addr = 1'b0; m_din = cur[15:8];
          end
        end
        if (host.wr_valid && old_ready) mq.push_back({host.wr_reg, host.wr_val});
        m_ready = (mq.size() < DEPTH);
      end
      m_busy = (mq.size() != 0) || act;
    end
  end

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endfunction

  // scoreboard of bus strobes: {addr, din} captured on each cs_n fall
  logic [8:0] log_q[$];
  logic [8:0] exp_q[$];

  initial begin : compare
    logic prev_cs;
    prev_cs = 1'b1;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("level", level, mq.size());
        chk("wr_ready", host.wr_ready, m_ready);
        chk("ovf", ovf, m_ovf);
        chk("busy", busy, m_busy);
        chk("cs_n", opl_cs_n, m_cs_n);
        chk("wr_n", opl_wr_n, m_cs_n);
        chk("addr", opl_addr, m_addr);
        chk("din", opl_din, m_din);
        if (prev_cs === 1'b1 && opl_cs_n === 1'b0) log_q.push_back({opl_addr, opl_din});
        prev_cs = opl_cs_n;
      end
    end
  end

  // driver tasks; all are entered and left on a negedge
  task automatic push(input logic [7:0] r, input logic [7:0] v);
    host.wr_reg = r; host.wr_val = v; host.wr_valid = 1'b1;
    @(negedge clk);
    host.wr_valid = 1'b0;
  endtask

  function automatic bit ev(input int kind);
    case (kind)
      0:       return (opl_cs_n === 1'b0) && (opl_addr === 1'b0);
      1:       return (opl_cs_n === 1'b0) && (opl_addr === 1'b1);
      default: return (busy === 1'b0);
    endcase
  endfunction

  task automatic wait_ev(input int kind, input int limit, output int n);
    n = 0;
    while (!ev(kind) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("wait_event", ev(kind), 1);
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk(name, log_q[i], exp_q[i]);
  endtask

  initial begin : main
    int n;
    int n2;
    logic [7:0] r;
    logic [7:0] v;
    rst = 1'b1; cen = 1'b0; clr_ovf = 1'b0;
    host.wr_valid = 1'b0; host.wr_reg = 8'h00; host.wr_val = 8'h00;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_ready", host.wr_ready, 0);
    chk("rst_cs_n", opl_cs_n, 1);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", host.wr_ready, 1);

    // single write timing
    cen = 1'b1;
    push(8'h20, 8'h01);
    wait_ev(0, 20, n);
    chk("t1_addr_din", opl_din, 8'h20);
    chk("t1_addr_sel", opl_addr, 0);
    @(negedge clk);
    chk("t1_strobe_width", opl_cs_n, 1);
    wait_ev(1, 50, n);
    chk("t1_data_time", n + 1, 13);
    chk("t1_data_din", opl_din, 8'h01);
    wait_ev(2, 200, n2);
    chk("t1_idle_time", n + 1 + n2, 98);

    // fill while frozen, overflow, then drain in order
    cen = 1'b0;
    log_q.delete(); exp_q.delete();
    for (int i = 0; i < 17; i++) begin
      r = 8'($urandom_range(0, 255)); v = 8'($urandom_range(0, 255));
      if (i < 16) begin exp_q.push_back({1'b0, r}); exp_q.push_back({1'b1, v}); end
      push(r, v);
    end
    chk("t2_level", level, 16);
    chk("t2_ready", host.wr_ready, 0);
    chk("t2_ovf", ovf, 1);
    cen = 1'b1;
    wait_ev(2, 16 * 100 + 50, n);
    check_log("t2_order");
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("t2_clr_ovf", ovf, 0);

    // back-to-back writes: next address 85 ticks after the data strobe
    push(8'hA0, 8'h11);
    push(8'hB0, 8'h22);
    wait_ev(1, 50, n);
    @(negedge clk);
    wait_ev(0, 200, n);
    chk("t3_gap", n + 1, 85);
    chk("t3_din", opl_din, 8'hB0);
    wait_ev(2, 300, n);

    // freeze inside the address wait
    push(8'h40, 8'h3F);
    wait_ev(0, 20, n);
    repeat (5) @(negedge clk);
    cen = 1'b0;
    repeat (20) @(negedge clk);
    chk("t4_frozen_din", opl_din, 8'h40);
    chk("t4_frozen_cs", opl_cs_n, 1);
    cen = 1'b1;
    wait_ev(1, 50, n);
    chk("t4_slip", 25 + n, 33);
    wait_ev(2, 200, n);

    // reset during the data strobe, then a clean write
    cen = 1'b0;
    for (int i = 0; i < 17; i++) push(8'(i), 8'(255 - i));
    cen = 1'b1;
    wait_ev(1, 200, n);
    chk("t5_ovf_before", ovf, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_cs_n", opl_cs_n, 1);
    chk("t5_wr_n", opl_wr_n, 1);
    chk("t5_level", level, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);
    log_q.delete(); exp_q.delete();
    exp_q.push_back({1'b0, 8'hBD}); exp_q.push_back({1'b1, 8'h20});
    push(8'hBD, 8'h20);
    wait_ev(2, 200, n);
    check_log("t5_replay");

    // randomized traffic
    for (int chunk = 0; chunk < 8; chunk++) begin
      int rate;
      rate = $urandom_range(2, 40);
      for (int c = 0; c < 500; c++) begin
        cen = ($urandom_range(0, 3) != 0);
        clr_ovf = ($urandom_range(0, 49) == 0);
        rst = ($urandom_range(0, 1999) == 0);
        host.wr_valid = ($urandom_range(0, rate) == 0);
        host.wr_reg = 8'($urandom_range(0, 255));
        host.wr_val = 8'($urandom_range(0, 255));
        @(negedge clk);
      end
    end
    rst = 1'b0; cen = 1'b1; clr_ovf = 1'b0; host.wr_valid = 1'b0;
    wait_ev(2, 3000, n);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
